count_capture_unit: RTL and testbench
=====================================

Name: count_capture_unit

Overview:
- Downstream consumer of the 4-bit synchronous up-counter output (`bin_sync_up.out`).
- Detects counter wrap and extends the count to WIDTH+EXT_WIDTH bits.
- Raises a one-cycle pulse when the counter first reaches a programmable compare value.
- Snapshots the extended count into a capture register, drained by a valid/ready handshake.

Parameters:
- WIDTH, 4, width of the incoming counter value; counter max = 2^WIDTH-1.
- EXT_WIDTH, 8, width of the wrap (extension) counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cnt_in  input  WIDTH  counter value from upstream up-counter
- cmp_val  input  WIDTH  compare value, sampled every cycle
- cmp_en  input  1  enables match detection
- capture_req  input  1  single-cycle request to snapshot the extended count
- wrap_pulse  output  1  one-cycle pulse per detected wrap
- match_pulse  output  1  one-cycle pulse on first cycle cnt_in equals cmp_val
- wrap_cnt  output  EXT_WIDTH  number of wraps since reset, modulo 2^EXT_WIDTH
- ext_ovf  output  1  sticky: wrap_cnt has rolled over
- cap_data  output  EXT_WIDTH+WIDTH  captured {wrap_cnt, cnt_in}
- cap_valid  output  1  cap_data holds an unconsumed capture
- cap_ready  input  1  downstream accepts cap_data when cap_valid && cap_ready
- cap_overrun  output  1  sticky: a capture request was dropped

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is synchronous and active-high.
  - Every output is registered.
  - On reset: wrap_pulse=0, match_pulse=0, wrap_cnt=0, ext_ovf=0, cap_data=0, cap_valid=0, cap_overrun=0, internal cnt_q=0, primed=0, FSM=IDLE.
  - Reset asserted mid-operation discards any pending capture (cap_valid drops the next edge) and clears all sticky flags.
- Sampling:
  - cnt_q <= cnt_in every cycle.
  - primed <= 1 on the first cycle out of reset.
  - No wrap or match is detected while primed=0. This prevents false events from the cnt_q reset value.
- Wrap detection (wrap_det):
  - wrap_det = primed && cnt_q == 2^WIDTH-1 && cnt_in == 0.
  - wrap_pulse is high the cycle after wrap_det (1-cycle latency).
  - wrap_cnt increments in the same edge.
  - At wrap_cnt = 2^EXT_WIDTH-1, the next wrap sets wrap_cnt to 0 and ext_ovf to 1 (sticky).
- Match detection:
  - match_det = primed && cmp_en && cnt_in == cmp_val && cnt_in != cnt_q.
  - Fires only on entry to the value, so a stalled counter gives one pulse.
  - match_pulse is high the cycle after match_det.
  - A cmp_val change onto the currently held count produces no pulse.
- Capture FSM, two states:
  - IDLE: cap_valid=0. capture_req -> load cap_data, go to HOLD.
  - HOLD: cap_valid=1, cap_data stable.
    - cap_ready=1 without capture_req -> IDLE.
    - cap_ready=1 with capture_req -> reload cap_data, stay HOLD (no drop).
    - capture_req without cap_ready -> request dropped, cap_overrun<=1, cap_data unchanged.
- Snapshot value:
  - Captured value = {wrap_cnt_next, cnt_in}, where wrap_cnt_next = wrap_cnt+1 if wrap_det this cycle, else wrap_cnt.
  - The snapshot is therefore always self-consistent across a wrap.
  - cap_valid rises 1 cycle after capture_req.
- Arithmetic: all counts are unsigned; no saturation.

Optional Feature:
- CCU_AUTO_CAPTURE_EN
- Defined: match_det acts as an additional capture request, OR'd with capture_req and subject to the same HOLD/overrun rules. It captures the count at the match cycle.
- Undefined: captures occur only on capture_req. Match only drives match_pulse.

Test Plan:
- Reset, then counter free-runs 0..15,0 with cap_ready=1 -> wrap_pulse high exactly one cycle after cnt_in goes 15->0; wrap_cnt=1; no pulse on first post-reset cycle.
- cmp_en=1, cmp_val=9, counter holds 9 for 3 cycles -> exactly one match_pulse, one cycle after cnt_in first equals 9; cmp_val changed to 9 while holding 9 -> no pulse.
- 256 wraps -> wrap_cnt returns to 0, ext_ovf=1 and stays 1 until reset.
- cap_ready=0, capture_req at cnt_in=5, wrap_cnt=3 -> cap_valid=1, cap_data=0x035; second capture_req -> cap_overrun=1, cap_data stays 0x035; cap_ready=1 -> cap_valid=0 next cycle.
- capture_req in the same cycle cnt_in goes 15->0 with wrap_cnt=2 -> cap_data=0x030; capture_req coincident with HOLD handshake -> cap_valid stays 1 with new data, cap_overrun unchanged.
- reset asserted while cap_valid=1 and ext_ovf=1 -> next edge all outputs 0; with CCU_AUTO_CAPTURE_EN, cmp_val=7 -> cap_valid rises with cap_data low nibble=7, no capture_req.

Source files
------------

// File: rtl/count_capture_unit.sv
// Wrap-extending capture unit for an upstream WIDTH-bit up-counter.
// Optional macro CCU_AUTO_CAPTURE_EN: a compare match also requests a capture.
module count_capture_unit #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned EXT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           cnt_in,
  input  logic [WIDTH-1:0]           cmp_val,
  input  logic                       cmp_en,
  input  logic                       capture_req,
  output logic                       wrap_pulse,
  output logic                       match_pulse,
  output logic [EXT_WIDTH-1:0]       wrap_cnt,
  output logic                       ext_ovf,
  output logic [EXT_WIDTH+WIDTH-1:0] cap_data,
  output logic                       cap_valid,
  input  logic                       cap_ready,
  output logic                       cap_overrun
);

  localparam int unsigned CAP_W = EXT_WIDTH + WIDTH;

  typedef enum logic {IDLE, HOLD} cap_state_e;

  cap_state_e           state_q;
  logic [WIDTH-1:0]     cnt_q;
  logic                 primed_q;
  logic                 wrap_pulse_q;
  logic                 match_pulse_q;
  logic [EXT_WIDTH-1:0] wrap_cnt_q;
  logic                 ext_ovf_q;
  logic [CAP_W-1:0]     cap_data_q;
  logic                 cap_valid_q;
  logic                 cap_overrun_q;

  logic                 wrap_det;
  logic                 match_det;
  logic                 cap_req;
  logic [EXT_WIDTH-1:0] wrap_cnt_d;
  logic [CAP_W-1:0]     snap_d;

  // Event detection; primed_q masks the cycle where cnt_q still holds its reset value.
  always_comb begin
    wrap_det   = primed_q && (cnt_q == {WIDTH{1'b1}}) && (cnt_in == '0);
    match_det  = primed_q && cmp_en && (cnt_in == cmp_val) && (cnt_in != cnt_q);
    wrap_cnt_d = wrap_det ? (wrap_cnt_q + EXT_WIDTH'(1)) : wrap_cnt_q;
    snap_d     = {wrap_cnt_d, cnt_in};
`ifdef CCU_AUTO_CAPTURE_EN
    cap_req    = capture_req | match_det;
`else
    cap_req    = capture_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      primed_q      <= 1'b0;
      wrap_pulse_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      wrap_cnt_q    <= '0;
      ext_ovf_q     <= 1'b0;
      cap_data_q    <= '0;
      cap_valid_q   <= 1'b0;
      cap_overrun_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_in;
      primed_q      <= 1'b1;
      wrap_pulse_q  <= wrap_det;
      match_pulse_q <= match_det;
      wrap_cnt_q    <= wrap_cnt_d;
      if (wrap_det && (wrap_cnt_q == {EXT_WIDTH{1'b1}})) begin
        ext_ovf_q <= 1'b1;
      end
      // Capture handshake: a request while HOLD and not drained is dropped.
      case (state_q)
        IDLE: begin
          if (cap_req) begin
            cap_data_q  <= snap_d;
            cap_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (cap_ready) begin
            if (cap_req) begin
              cap_data_q <= snap_d;
            end else begin
              cap_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end else if (cap_req) begin
            cap_overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cap_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign wrap_pulse  = wrap_pulse_q;
  assign match_pulse = match_pulse_q;
  assign wrap_cnt    = wrap_cnt_q;
  assign ext_ovf     = ext_ovf_q;
  assign cap_data    = cap_data_q;
  assign cap_valid   = cap_valid_q;
  assign cap_overrun = cap_overrun_q;

endmodule

// File: tb/tb_count_capture_unit.sv
// Directed bench for count_capture_unit; captures are checked through a scoreboard queue.
module tb_count_capture_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cnt_in;
  logic [3:0]  cmp_val;
  logic        cmp_en;
  logic        capture_req;
  logic        wrap_pulse;
  logic        match_pulse;
  logic [7:0]  wrap_cnt;
  logic        ext_ovf;
  logic [11:0] cap_data;
  logic        cap_valid;
  logic        cap_ready;
  logic        cap_overrun;

  int passed = 0;
  int total  = 0;
  int pulses;
  logic [11:0] sb_q[$];

  count_capture_unit #(.WIDTH(4), .EXT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cmp_val(cmp_val), .cmp_en(cmp_en),
    .capture_req(capture_req), .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
    .wrap_cnt(wrap_cnt), .ext_ovf(ext_ovf), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_overrun(cap_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one edge; any handshake about to happen is scored first.
  task automatic tick();
    logic [11:0] exp;
    if (cap_valid === 1'b1 && cap_ready === 1'b1) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'(cap_valid), 32'd0);
      else begin
        exp = sb_q.pop_front();
        check("sb_data", 32'(cap_data), 32'(exp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v);
    cnt_in = 4'(v);
    tick();
  endtask

  task automatic drive_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      drive(v);
      if (wrap_pulse === 1'b1) pulses++;
    end
  endtask

  initial begin
    reset = 1'b1; cnt_in = '0; cmp_val = '0; cmp_en = 1'b0;
    capture_req = 1'b0; cap_ready = 1'b1;
    tick(); tick();
    check("rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
    check("rst_match_pulse", 32'(match_pulse), 32'd0);
    check("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
    check("rst_ext_ovf", 32'(ext_ovf), 32'd0);
    check("rst_cap", 32'({cap_valid, cap_overrun, cap_data}), 32'd0);

    // First post-reset cycle: cnt_in differs from the reset cnt_q but no event may fire.
    reset = 1'b0; cmp_en = 1'b1; cmp_val = 4'd3;
    drive(3);
    check("primed_match", 32'(match_pulse), 32'd0);
    check("primed_wrap", 32'(wrap_pulse), 32'd0);
    cmp_en = 1'b0;

    // Free-run to a wrap.
    pulses = 0;
    drive_range(4, 15);
    check("no_early_wrap", 32'(pulses), 32'd0);
    drive(0);
    check("wrap_pulse", 32'(wrap_pulse), 32'd1);
    check("wrap_cnt_1", 32'(wrap_cnt), 32'd1);
    drive(1);
    check("wrap_pulse_1cyc", 32'(wrap_pulse), 32'd0);

    // Match on entry only; a stalled count or cmp_val moving onto it gives no pulse.
    cmp_en = 1'b1; cmp_val = 4'd9;
    drive_range(2, 8);
    check("no_early_match", 32'(match_pulse), 32'd0);
`ifdef CCU_AUTO_CAPTURE_EN
    sb_q.push_back(12'h019);
`endif
    drive(9);
    check("match_pulse", 32'(match_pulse), 32'd1);
    pulses = 0;
    drive(9); if (match_pulse === 1'b1) pulses++;
    drive(9); if (match_pulse === 1'b1) pulses++;
    cmp_val = 4'd0;
    drive(9); if (match_pulse === 1'b1) pulses++;
    cmp_val = 4'd9;
    drive(9); if (match_pulse === 1'b1) pulses++;
    check("match_stall_pulses", 32'(pulses), 32'd0);
    cmp_en = 1'b0;

    // Capture coincident with a wrap: snapshot carries the incremented wrap count.
    drive_range(10, 15);
    drive(0);
    check("wrap_cnt_2", 32'(wrap_cnt), 32'd2);
    drive_range(1, 15);
    cap_ready = 1'b0; capture_req = 1'b1;
    sb_q.push_back(12'h030);
    drive(0);
    capture_req = 1'b0;
    check("cap_wrap_valid", 32'(cap_valid), 32'd1);
    check("cap_wrap_data", 32'(cap_data), 32'h030);
    check("cap_wrap_cnt", 32'(wrap_cnt), 32'd3);
    drive_range(1, 3);
    check("hold_stable", 32'(cap_data), 32'h030);
    cap_ready = 1'b1;
    drive(4);
    check("drain_valid", 32'(cap_valid), 32'd0);

    // Capture, reload on handshake, then overrun.
    cap_ready = 1'b0; capture_req = 1'b1;
    sb_q.push_back(12'h035);
    drive(5);
    check("cap5_valid", 32'(cap_valid), 32'd1);
    check("cap5_data", 32'(cap_data), 32'h035);
    cap_ready = 1'b1;
    sb_q.push_back(12'h036);
    drive(6);
    check("reload_valid", 32'(cap_valid), 32'd1);
    check("reload_data", 32'(cap_data), 32'h036);
    check("reload_no_ovr", 32'(cap_overrun), 32'd0);
    cap_ready = 1'b0;
    drive(7);
    check("overrun_set", 32'(cap_overrun), 32'd1);
    check("overrun_data", 32'(cap_data), 32'h036);
    capture_req = 1'b0; cap_ready = 1'b1;
    drive(8);
    check("drain2_valid", 32'(cap_valid), 32'd0);
    check("overrun_sticky", 32'(cap_overrun), 32'd1);

    // Extension rollover after 256 wraps in total.
    drive_range(9, 15);
    for (int i = 0; i < 252; i++) begin
      drive(0);
      drive_range(1, 15);
    end
    check("wrap_cnt_255", 32'(wrap_cnt), 32'd255);
    check("ovf_before", 32'(ext_ovf), 32'd0);
    drive(0);
    check("wrap_cnt_roll", 32'(wrap_cnt), 32'd0);
    check("ovf_set", 32'(ext_ovf), 32'd1);
    drive_range(1, 15);
    drive(0);
    check("ovf_sticky", 32'(ext_ovf), 32'd1);
    check("wrap_cnt_after", 32'(wrap_cnt), 32'd1);

    // Reset while holding a capture with sticky flags set.
    cap_ready = 1'b0; capture_req = 1'b1;
    sb_q.push_back(12'h011);
    drive(1);
    check("pre_rst_data", 32'(cap_data), 32'h011);
    drive(2);
    check("pre_rst_ovr", 32'(cap_overrun), 32'd1);
    reset = 1'b1; capture_req = 1'b0;
    tick();
    sb_q.delete();
    check("mid_rst_outputs",
          32'({wrap_pulse, match_pulse, wrap_cnt, ext_ovf, cap_data, cap_valid, cap_overrun}), 32'd0);

    // Match-driven capture (auto-capture builds only).
    reset = 1'b0; cmp_en = 1'b1; cmp_val = 4'd7;
    drive_range(0, 6);
`ifdef CCU_AUTO_CAPTURE_EN
    sb_q.push_back(12'h007);
`endif
    drive(7);
    check("auto_match_pulse", 32'(match_pulse), 32'd1);
`ifdef CCU_AUTO_CAPTURE_EN
    check("auto_cap_valid", 32'(cap_valid), 32'd1);
    check("auto_cap_nibble", 32'(cap_data[3:0]), 32'd7);
`else
    check("no_auto_cap", 32'(cap_valid), 32'd0);
`endif
    cap_ready = 1'b1;
    drive(8);
    check("final_valid", 32'(cap_valid), 32'd0);
    check("sb_left", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
